// File: rtl/pattern_match_ctrl_pkg.sv
// rtl/pattern_match_ctrl_pkg.sv - shared state encoding and default widths for the pattern matcher
package pattern_match_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_PAT_LEN = 8;
  localparam int DEF_POS_W   = 16;
  localparam int DEF_CNT_W   = 8;
endpackage

// File: rtl/pm_char_cell.sv
// rtl/pm_char_cell.sv - one NFA position: compare text bit to pattern char, enabled state flop
module pm_char_cell (
  input  logic clk,
  input  logic reset_,
  input  logic en,
  input  logic prev,
  input  logic pat_bit,
  input  logic in_bit,
  output logic act
);
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      act <= 1'b0;
    end else if (en) begin
      act <= prev & (in_bit ~^ pat_bit);
    end
  end
endmodule

// File: rtl/pattern_match_ctrl.sv
// rtl/pattern_match_ctrl.sv - pattern load / text stream sequencer around a chain of NFA cells
module pattern_match_ctrl
  import pattern_match_ctrl_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter int POS_W   = DEF_POS_W,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int LW     = $clog2(PAT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             start,
  input  logic [LW-1:0]    pat_len,
  input  logic             load_valid,
  input  logic             load_bit,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             in_ready,
  output logic             match,
  output logic [POS_W-1:0] match_pos,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);
  state_t state_q, state_d;

  logic [LW-1:0]      len_q, load_cnt, len_clamped;
  logic [PAT_LEN-1:0] pat, act, prev, keep_mask, last_mask;
  logic [POS_W-1:0]   pos;
  logic               run, load, accept, acc_q, cell_en;

  assign run      = (state_q == ST_RUN);
  assign load     = (state_q == ST_LOAD);
  assign accept   = in_valid & run;
  assign in_ready = run;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign cell_en  = accept | load;

  always_comb begin
    len_clamped = pat_len;
    if (pat_len == '0) begin
      len_clamped = LW'(1);
    end else if (pat_len > LW'(PAT_LEN)) begin
      len_clamped = LW'(PAT_LEN);
    end
  end

  always_comb begin
    keep_mask = '0;
    last_mask = '0;
    for (int k = 0; k < PAT_LEN; k++) begin
      keep_mask[k] = (LW'(k) < len_q);
      last_mask[k] = (LW'(k + 1) == len_q);
    end
  end

  // Forcing prev low while loading flushes every cell in a single cycle.
  assign prev  = run ? ({act[PAT_LEN-2:0], 1'b1} & keep_mask) : '0;
  assign match = acc_q & |(act & last_mask);

  for (genvar g = 0; g < PAT_LEN; g++) begin : g_cell
    pm_char_cell u_cell (
      .clk     (clk),
      .reset_  (reset_),
      .en      (cell_en),
      .prev    (prev[g]),
      .pat_bit (pat[g]),
      .in_bit  (in_bit),
      .act     (act[g])
    );
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (load_valid && (load_cnt == len_q - LW'(1))) state_d = ST_RUN;
      ST_RUN:  if (accept && in_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      len_q     <= '0;
      load_cnt  <= '0;
      pat       <= '0;
      pos       <= '0;
      acc_q     <= 1'b0;
      match_pos <= '0;
      match_cnt <= '0;
    end else begin
      acc_q <= accept;
      if ((state_q == ST_IDLE) && start) begin
        len_q     <= len_clamped;
        load_cnt  <= '0;
        pos       <= '0;
        match_cnt <= '0;
      end else if (match && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
      if (load && load_valid) begin
        for (int k = 0; k < PAT_LEN; k++) begin
          if (load_cnt == LW'(k)) pat[k] <= load_bit;
        end
        load_cnt <= load_cnt + LW'(1);
      end
      if (accept) begin
        match_pos <= pos;
        pos       <= pos + POS_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pattern_match_ctrl.sv
// tb/tb_pattern_match_ctrl.sv - randomized self-checking bench against a substring-search model
module tb_pattern_match_ctrl;
  typedef bit bq_t[$];
  typedef int iq_t[$];

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  pat_len = '0;
  logic        load_valid = 1'b0, load_bit = 1'b0;
  logic        in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0;
  logic        in_ready, match, busy, done;
  logic [15:0] match_pos;
  logic [7:0]  match_cnt;
  logic        in_ready2, match2, busy2, done2;
  logic [15:0] match_pos2;
  logic [1:0]  match_cnt2;

  int n_checks = 0;
  int n_fail = 0;
  iq_t obs_q;
  int done_cnt = 0;
  bit done_match = 0;
  int m2_cnt = 0;

  pattern_match_ctrl #(.PAT_LEN(8), .POS_W(16), .CNT_W(8)) dut (
    .clk(clk), .reset_(reset_), .start(start), .pat_len(pat_len),
    .load_valid(load_valid), .load_bit(load_bit),
    .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
    .in_ready(in_ready), .match(match), .match_pos(match_pos),
    .match_cnt(match_cnt), .busy(busy), .done(done)
  );

  pattern_match_ctrl #(.PAT_LEN(4), .POS_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .reset_(reset_), .start(start), .pat_len(pat_len[2:0]),
    .load_valid(load_valid), .load_bit(load_bit),
    .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last),
    .in_ready(in_ready2), .match(match2), .match_pos(match_pos2),
    .match_cnt(match_cnt2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (match) obs_q.push_back(int'(match_pos));
    if (done) begin
      done_cnt++;
      done_match = match;
    end
    if (match2) m2_cnt++;
  end

  function automatic int eff_len(int l);
    if (l < 1) return 1;
    if (l > 8) return 8;
    return l;
  endfunction

  // Every end index where the text window equals the pattern.
  function automatic iq_t model(bq_t p, bq_t t);
    iq_t r;
    for (int i = p.size() - 1; i < t.size(); i++) begin
      bit ok = 1;
      for (int j = 0; j < p.size(); j++) if (t[i - p.size() + 1 + j] != p[j]) ok = 0;
      if (ok) r.push_back(i);
    end
    return r;
  endfunction

  function automatic bit same_q(iq_t a, iq_t b);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] != b[i]) return 0;
    return 1;
  endfunction

  task automatic clear_obs();
    obs_q.delete();
    done_cnt = 0;
    done_match = 0;
    m2_cnt = 0;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    pat_len = 4'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_load(input bq_t p);
    foreach (p[i]) begin
      load_valid = 1'b1;
      load_bit = p[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
  endtask

  task automatic do_text(input bq_t t, input int gap, input bit rnd);
    foreach (t[i]) begin
      if (i > 0) repeat (rnd ? $urandom_range(gap, 0) : gap) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_bit = t[i];
      in_last = (i == t.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last = 1'b0;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, in_ready, match, done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, in_ready, match, done});
    end
    n_checks++;
    if (match_pos !== 16'd0 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_counters got pos=%0d cnt=%0d want 0 0", match_pos, match_cnt);
    end
    @(negedge clk);
    reset_ = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input string name, input int gap);
    bq_t p = '{1, 0, 1, 1};
    bq_t t = '{1, 0, 1, 1, 0, 1, 1};
    iq_t exp = '{3, 6};
    clear_obs();
    do_start(4);
    do_load(p);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_ready got %b want 1", name, in_ready);
    end
    do_text(t, gap, 0);
    n_checks++;
    if (!same_q(obs_q, exp)) begin
      n_fail++; $display("FAIL %s_pos got %p want %p", name, obs_q, exp);
    end
    n_checks++;
    if (match_cnt !== 8'd2) begin
      n_fail++; $display("FAIL %s_cnt got %0d want 2", name, match_cnt);
    end
    n_checks++;
    if (done_cnt != 1 || done_match != 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_done got n=%0d with_match=%0d busy=%b want 1 1 0", name, done_cnt, done_match, busy);
    end
  endtask

  task automatic test_overlap();
    bq_t p = '{1, 1};
    bq_t t = '{1, 1, 1, 1};
    iq_t exp = '{1, 2, 3};
    clear_obs();
    do_start(2);
    do_load(p);
    do_text(t, 0, 0);
    n_checks++;
    if (!same_q(obs_q, exp)) begin
      n_fail++; $display("FAIL overlap_pos got %p want %p", obs_q, exp);
    end
    n_checks++;
    if (match_cnt !== 8'd3) begin
      n_fail++; $display("FAIL overlap_cnt got %0d want 3", match_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bq_t p = '{1, 0, 1, 1};
    clear_obs();
    do_start(4);
    do_load(p);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_bit = p[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    n_checks++;
    if ({busy, in_ready, match, done} !== 4'b0 || match_pos !== 16'd0 || match_cnt !== 8'd0) begin
      n_fail++; $display("FAIL midreset_outputs got flags=%b pos=%0d cnt=%0d want 0",
                         {busy, in_ready, match, done}, match_pos, match_cnt);
    end
    @(negedge clk);
    reset_ = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_nodone got n=%0d busy=%b want 0 0", done_cnt, busy);
    end
    test_basic("rerun", 0);
  endtask

  task automatic test_saturate();
    bq_t p = '{0};
    bq_t t = '{0, 0, 0, 0, 0, 0};
    clear_obs();
    do_start(1);
    do_load(p);
    do_text(t, 0, 0);
    n_checks++;
    if (m2_cnt != 6 || obs_q.size() != 6) begin
      n_fail++; $display("FAIL sat_pulses got %0d/%0d want 6/6", m2_cnt, obs_q.size());
    end
    n_checks++;
    if (match_cnt2 !== 2'd3) begin
      n_fail++; $display("FAIL sat_cnt2 got %0d want 3", match_cnt2);
    end
    n_checks++;
    if (match_cnt !== 8'd6) begin
      n_fail++; $display("FAIL sat_cnt got %0d want 6", match_cnt);
    end
  endtask

  task automatic test_ignore();
    bq_t t = '{0, 1, 1, 1};
    iq_t exp = '{1, 2, 3};
    clear_obs();
    load_valid = 1'b1; in_valid = 1'b1; load_bit = 1'b0;
    @(posedge clk); #1;
    load_valid = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore got busy=%b ready=%b want 0 0", busy, in_ready);
    end
    do_start(0);
    do_load('{1});
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL len0_clamp got ready=%b want 1", in_ready);
    end
    foreach (t[i]) begin
      in_valid = 1'b1;
      in_bit = t[i];
      in_last = (i == 3);
      start = (i == 2);
      pat_len = 4'd5;
      load_valid = (i == 2);
      load_bit = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; load_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (!same_q(obs_q, exp) || match_cnt !== 8'd3) begin
      n_fail++; $display("FAIL ignore_run got %p cnt=%0d want %p cnt=3", obs_q, match_cnt, exp);
    end
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_done got n=%0d busy=%b want 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_clamp_max();
    bq_t p = '{1, 0, 0, 1, 1, 0, 1, 0};
    bq_t t = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};
    iq_t exp;
    clear_obs();
    do_start(15);
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1; load_bit = p[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clamp_early got ready=%b want 0", in_ready);
    end
    do_load('{p[7]});
    exp = model(p, t);
    do_text(t, 1, 1);
    n_checks++;
    if (!same_q(obs_q, exp)) begin
      n_fail++; $display("FAIL clamp_pos got %p want %p", obs_q, exp);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int len_in = $urandom_range(12, 0);
      int l = eff_len(len_in);
      int n = $urandom_range(30, 1);
      bq_t p, t;
      iq_t exp;
      for (int j = 0; j < l; j++) p.push_back(1'($urandom));
      for (int j = 0; j < n; j++) t.push_back(1'($urandom));
      if (n >= l && $urandom_range(1, 0) == 1) begin
        int at = $urandom_range(n - l, 0);
        for (int j = 0; j < l; j++) t[at + j] = p[j];
      end
      exp = model(p, t);
      clear_obs();
      do_start(len_in);
      do_load(p);
      do_text(t, 2, 1);
      n_checks++;
      if (!same_q(obs_q, exp)) begin
        n_fail++; $display("FAIL rand%0d_pos got %p want %p", it, obs_q, exp);
      end
      n_checks++;
      if (int'(match_cnt) != ((exp.size() > 255) ? 255 : exp.size())) begin
        n_fail++; $display("FAIL rand%0d_cnt got %0d want %0d", it, match_cnt, exp.size());
      end
      n_checks++;
      if (done_cnt != 1 || done_match != (exp.size() > 0 && exp[exp.size() - 1] == n - 1)) begin
        n_fail++; $display("FAIL rand%0d_done got n=%0d with_match=%0d", it, done_cnt, done_match);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic("basic", 0);
    test_overlap();
    test_basic("gaps", 3);
    test_reset_mid();
    test_saturate();
    test_ignore();
    test_clamp_max();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
